// File: rtl/beep_defs.sv
// Shared definitions for the buzzer melody player: FSM encoding, note
// frequencies, half-period helper and the melody ROM.
package beep_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NOTE = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int F_C4 = 262;
    localparam int F_E4 = 330;
    localparam int F_G4 = 392;
    localparam int F_C5 = 523;
    localparam int F_E5 = 659;
    localparam int F_G5 = 784;
    localparam int F_C6 = 1047;

    localparam int WIN_LEN  = 4;
    localparam int FAIL_LEN = 3;
    localparam int MAX_LEN  = 4;

    localparam int IDX_W  = 2;
    localparam int HALF_W = 20;
    localparam int MS_W   = 16;
    localparam int TICK_W = 20;

    function automatic int half_cycles(input int clk_hz, input int freq_hz);
        return clk_hz / (2 * freq_hz);
    endfunction

    // Indices past the end of a melody repeat its final note.
    function automatic int melody_freq(input logic win, input int idx);
        int f;
        f = F_C4;
        if (win) begin
            case (idx)
                0:       f = F_C5;
                1:       f = F_E5;
                2:       f = F_G5;
                default: f = F_C6;
            endcase
        end else begin
            case (idx)
                0:       f = F_G4;
                1:       f = F_E4;
                default: f = F_C4;
            endcase
        end
        return f;
    endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave divider: toggles the output every `half` enabled cycles,
// holding divider and output at zero while disabled.
module tone_gen
    import beep_defs::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [HALF_W-1:0] half,
    output logic              wave
);

    logic [HALF_W-1:0] div_reg;
    logic              wave_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg  <= '0;
            wave_reg <= 1'b0;
        end else if (!en) begin
            div_reg  <= '0;
            wave_reg <= 1'b0;
        end else if (div_reg == half - HALF_W'(1)) begin
            div_reg  <= '0;
            wave_reg <= ~wave_reg;
        end else begin
            div_reg <= div_reg + HALF_W'(1);
        end
    end

    assign wave = wave_reg;

endmodule

// File: rtl/beep_player.sv
// Plays a win or fail melody on a passive buzzer after a start edge,
// with busy while playing and a one-cycle over pulse on completion.
module beep_player
    import beep_defs::*;
#(
    parameter int CLK_FREQ_HZ  = 1_000_000,
    parameter int NOTE_WIN_MS  = 150,
    parameter int NOTE_FAIL_MS = 300,
    parameter int GAP_MS       = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic st,
    input  logic win,
    input  logic stop,
    output logic beep,
    output logic busy,
    output logic over
);

    localparam int TICK_CYCLES = CLK_FREQ_HZ / 1000;

    state_t             state_reg, state_next;
    logic               st_sync_reg, st_prev_reg, win_sync_reg;
    logic               win_reg, win_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [TICK_W-1:0]  tick_cnt_reg;
    logic [MS_W-1:0]    ms_cnt_reg;
    logic [MS_W-1:0]    seg_ms;
    logic               restart, ms_tick, seg_done, st_edge, last_note;
    logic [HALF_W-1:0]  half_rom [2][MAX_LEN];
    logic [HALF_W-1:0]  half_sel;
    logic               tone_wave;

    // Half-period table folds to constants: row 0 fail melody, row 1 win.
    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_half_rom
            assign half_rom[0][gi] = HALF_W'(half_cycles(CLK_FREQ_HZ, melody_freq(1'b0, gi)));
            assign half_rom[1][gi] = HALF_W'(half_cycles(CLK_FREQ_HZ, melody_freq(1'b1, gi)));
        end
    endgenerate

    assign half_sel = half_rom[win_reg][idx_reg];

    // st and win are registered together so the verdict lines up with the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_sync_reg  <= 1'b0;
            st_prev_reg  <= 1'b0;
            win_sync_reg <= 1'b0;
        end else begin
            st_sync_reg  <= st;
            st_prev_reg  <= st_sync_reg;
            win_sync_reg <= win;
        end
    end

    assign st_edge = st_sync_reg & ~st_prev_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_reg <= '0;
            ms_cnt_reg   <= '0;
        end else if (restart) begin
            tick_cnt_reg <= '0;
            ms_cnt_reg   <= '0;
        end else if (ms_tick) begin
            tick_cnt_reg <= '0;
            ms_cnt_reg   <= ms_cnt_reg + MS_W'(1);
        end else begin
            tick_cnt_reg <= tick_cnt_reg + TICK_W'(1);
        end
    end

    assign ms_tick   = (tick_cnt_reg == TICK_W'(TICK_CYCLES - 1));
    assign seg_ms    = (state_reg == GAP) ? MS_W'(GAP_MS)
                     : (win_reg ? MS_W'(NOTE_WIN_MS) : MS_W'(NOTE_FAIL_MS));
    assign seg_done  = ms_tick && (ms_cnt_reg == seg_ms - MS_W'(1));
    assign last_note = win_reg ? (idx_reg == IDX_W'(WIN_LEN - 1))
                               : (idx_reg == IDX_W'(FAIL_LEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            win_reg   <= 1'b0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            win_reg   <= win_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        win_next   = win_reg;
        idx_next   = idx_reg;
        restart    = 1'b0;
        if (stop) begin
            state_next = IDLE;
            restart    = 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    restart = 1'b1;
                    if (st_edge) begin
                        state_next = NOTE;
                        win_next   = win_sync_reg;
                        idx_next   = '0;
                    end
                end
                NOTE: begin
                    if (seg_done) begin
                        state_next = GAP;
                        restart    = 1'b1;
                    end
                end
                GAP: begin
                    if (seg_done) begin
                        restart = 1'b1;
                        if (last_note) begin
                            state_next = DONE;
                        end else begin
                            state_next = NOTE;
                            idx_next   = idx_reg + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    restart    = 1'b1;
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                    restart    = 1'b1;
                end
            endcase
        end
    end

    tone_gen u_tone_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state_reg == NOTE),
        .half (half_sel),
        .wave (tone_wave)
    );

    // The divider clears one cycle after leaving NOTE, so gate it here.
    assign beep = tone_wave & (state_reg == NOTE);
    assign busy = (state_reg != IDLE);
    assign over = (state_reg == DONE);

endmodule

// File: tb/tb_beep_player.sv
// Scoreboard bench for beep_player: stimulus queues expected note and over
// events, a negedge monitor measures the buzzer output and pops/compares.
module tb_beep_player;

    // Note and gap lengths are shortened tenfold; tone periods are unchanged.
    localparam int CLK_HZ    = 100_000;
    localparam int WIN_MS    = 15;
    localparam int FAIL_MS   = 30;
    localparam int GAP_MS    = 2;
    localparam int WIN_SPAN  = 1700;
    localparam int FAIL_SPAN = 3200;

    logic clk;
    logic rst, st, win, stop;
    logic beep, busy, over;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    ev_t exp_q[$];
    int  vectors;
    int  miscompares;
    int  cyc;

    beep_player #(
        .CLK_FREQ_HZ  (CLK_HZ),
        .NOTE_WIN_MS  (WIN_MS),
        .NOTE_FAIL_MS (FAIL_MS),
        .GAP_MS       (GAP_MS)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .st   (st),
        .win  (win),
        .stop (stop),
        .beep (beep),
        .busy (busy),
        .over (over)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic pop_check(input int kind, input int at, input int val);
        ev_t e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, at);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            check(kind == 1 ? "over_cycle" : "note_rise_cycle", at, e.cyc);
            if (kind == 0) check("half_period", val, e.val);
            $display("event kind=%0d cycle=%0d val=%0d", kind, at, val);
        end
    endtask

    // Hand-computed half periods at 100 kHz and per-note rise times.
    task automatic expect_melody(input logic w, input int c0, input int n, input logic with_over);
        int hw[4];
        int hf[3];
        ev_t e;
        hw = '{95, 75, 63, 47};
        hf = '{127, 151, 190};
        for (int i = 0; i < n; i++) begin
            e.kind = 0;
            e.val  = w ? hw[i] : hf[i];
            e.cyc  = c0 + 2 + i * (w ? WIN_SPAN : FAIL_SPAN) + e.val;
            exp_q.push_back(e);
        end
        if (with_over) begin
            e.kind = 1;
            e.val  = 0;
            e.cyc  = w ? c0 + 6802 : c0 + 9602;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic start_melody(input logic w, output int c0);
        @(negedge clk);
        win = w;
        st  = 1'b1;
        c0  = cyc;
        $display("start win=%0d at cycle %0d", w, c0);
    endtask

    // Monitor: a rise after >=195 silent cycles starts a note; its first
    // high run is the half period.
    initial begin
        int   low_cnt, hi_cnt, rise_cyc;
        logic prev_beep, in_first, after_over;
        low_cnt    = 1000;
        hi_cnt     = 0;
        rise_cyc   = 0;
        prev_beep  = 1'b0;
        in_first   = 1'b0;
        after_over = 1'b0;
        forever begin
            @(negedge clk);
            if (after_over) begin
                check("busy_after_over", int'(busy), 0);
                check("over_width", int'(over), 0);
            end
            after_over = 1'b0;
            if (over === 1'b1) begin
                pop_check(1, cyc, 0);
                after_over = 1'b1;
            end
            if (beep === 1'b1) begin
                if (!prev_beep && low_cnt >= 195) begin
                    in_first = 1'b1;
                    rise_cyc = cyc;
                    hi_cnt   = 0;
                end
                low_cnt = 0;
                if (in_first) hi_cnt++;
                prev_beep = 1'b1;
            end else begin
                if (in_first && prev_beep) begin
                    in_first = 1'b0;
                    pop_check(0, rise_cyc, hi_cnt);
                end
                low_cnt++;
                prev_beep = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        vectors     = 0;
        miscompares = 0;
        rst  = 1'b1;
        st   = 1'b0;
        win  = 1'b0;
        stop = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_beep", int'(beep), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_over", int'(over), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_busy", int'(busy), 0);

        // Win melody
        start_melody(1'b1, c0);
        expect_melody(1'b1, c0, 4, 1'b1);
        wait_cyc(c0 + 1);
        check("busy_before_accept", int'(busy), 0);
        wait_cyc(c0 + 2);
        check("busy_on_accept", int'(busy), 1);
        wait_cyc(c0 + 3);
        st = 1'b0;
        wait_cyc(c0 + 6802 + 50);

        // Fail melody with win toggled during playback
        start_melody(1'b0, c0);
        expect_melody(1'b0, c0, 3, 1'b1);
        wait_cyc(c0 + 3);
        st = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            wait_cyc(c0 + 500 * k);
            win = ~win;
        end
        wait_cyc(c0 + 9602 + 50);

        // Second st edge mid-melody, then st held high past completion
        start_melody(1'b1, c0);
        expect_melody(1'b1, c0, 4, 1'b1);
        wait_cyc(c0 + 400);
        st = 1'b0;
        wait_cyc(c0 + 500);
        st = 1'b1;
        wait_cyc(c0 + 6802 + 1000);
        check("held_st_no_restart", int'(busy), 0);
        st = 1'b0;
        repeat (300) @(negedge clk);

        // Abort with stop in note 2
        start_melody(1'b1, c0);
        expect_melody(1'b1, c0, 2, 1'b0);
        wait_cyc(c0 + 3);
        st = 1'b0;
        wait_cyc(c0 + 2000);
        check("busy_before_stop", int'(busy), 1);
        stop = 1'b1;
        @(negedge clk);
        check("stop_beep", int'(beep), 0);
        check("stop_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        stop = 1'b0;
        repeat (8000) @(negedge clk);
        check("stop_stays_idle", int'(busy), 0);

        // stop together with a start edge in IDLE
        @(negedge clk);
        stop = 1'b1;
        st   = 1'b1;
        win  = 1'b1;
        repeat (4) @(negedge clk);
        check("stop_st_busy", int'(busy), 0);
        stop = 1'b0;
        repeat (10) @(negedge clk);
        check("stop_st_discarded", int'(busy), 0);
        st = 1'b0;
        repeat (300) @(negedge clk);

        // Asynchronous reset mid-note, then a full replay
        start_melody(1'b1, c0);
        expect_melody(1'b1, c0, 1, 1'b0);
        wait_cyc(c0 + 3);
        st = 1'b0;
        wait_cyc(c0 + 300);
        check("pre_reset_beep", int'(beep), 1);
        check("pre_reset_busy", int'(busy), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_beep", int'(beep), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_over", int'(over), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        start_melody(1'b1, c0);
        expect_melody(1'b1, c0, 4, 1'b1);
        wait_cyc(c0 + 3);
        st = 1'b0;
        wait_cyc(c0 + 6802 + 50);

        check("pending_events", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/beep_player.md
Name: beep_player

Overview:
- Buzzer stage directly downstream of the game top-level FSM. It consumes the judge-state start pulse and the pass/fail verdict.
- Plays a short win or fail melody on a passive buzzer as a square wave.
- Raises `busy` while the melody plays and pulses `over` for one cycle when it finishes, so the FSM can advance.

Parameters:
- CLK_FREQ_HZ, 1_000_000, board clock frequency in Hz; all note and duration counts derive from it.
- NOTE_WIN_MS, 150, length of each win-melody note in ms.
- NOTE_FAIL_MS, 300, length of each fail-melody note in ms.
- GAP_MS, 20, silent gap after every note in ms.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- st  in  1  start request, level or pulse; accepted on its rising edge (0→1 between consecutive clk samples) while IDLE
- win  in  1  verdict, sampled in the same cycle st is accepted: 1 = win melody, 0 = fail melody
- stop  in  1  synchronous abort (game switched off); highest priority
- beep  out  1  buzzer drive, square wave; 0 when silent
- busy  out  1  high from the cycle after acceptance until the return to IDLE
- over  out  1  one-cycle pulse after the last gap of a completed melody

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is asynchronous and active-high (rst); registers clear immediately on rst assertion.
  - Reset values: beep=0, busy=0, over=0, state=IDLE, all counters 0, st edge register 0.
- Counts:
  - Half-period per note: HALF = CLK_FREQ_HZ / (2*f_note), integer truncation.
  - Millisecond tick: one clk pulse every CLK_FREQ_HZ/1000 cycles.
  - The tick counter restarts at every note and gap start, so durations are exact multiples of that period.
- Melodies, fixed sequences:
  - Win: C5 523, E5 659, G5 784, C6 1047 Hz; NOTE_WIN_MS each.
  - Fail: G4 392, E4 330, C4 262 Hz; NOTE_FAIL_MS each.
  - Every note is followed by a GAP_MS silence, including the last note.
- FSM states: IDLE, NOTE, GAP, DONE.
- IDLE:
  - beep=0, busy=0.
  - An st rising edge with stop=0: latch win, set note index to 0, go to NOTE. busy=1 from the next cycle.
- NOTE:
  - The tone divider counts to HALF-1 and then toggles beep. beep starts at 0 on note entry, so the first rising edge of beep comes HALF cycles after NOTE entry.
  - After the note's duration in ms ticks: beep forced 0, go to GAP.
- GAP:
  - beep=0.
  - After GAP_MS ticks: if this was the last note, go to DONE; otherwise increment the note index and go to NOTE.
- DONE:
  - over=1 for exactly this one cycle, busy=1.
  - Next cycle: IDLE with busy=0, over=0.
- Error and abort cases:
  - st edges while not IDLE are ignored; there is no queuing.
  - stop=1 in any state: next cycle IDLE, beep=0, busy=0, and no over pulse.
  - stop and an st edge in the same IDLE cycle: stop wins and the start is discarded.
  - st held high across a return to IDLE does not retrigger; a new 0→1 edge is required.
  - win changes after acceptance have no effect.
  - rst mid-melody: immediate silence and return to reset values.
- Latency: from the cycle st's rising edge is sampled to the over pulse:
  - win: 4*(NOTE_WIN_MS+GAP_MS) ms plus 2 cycles.
  - fail: 3*(NOTE_FAIL_MS+GAP_MS) ms plus 2 cycles.

Decomposition:
- Shared header/package beep_defs holds:
  - state encodings IDLE=0, NOTE=1, GAP=2, DONE=3;
  - note frequency constants;
  - the HALF(freq) constant function of CLK_FREQ_HZ;
  - the melody ROM (note index → frequency code, plus lengths 4 and 3).
- One sub-module, tone_gen. It takes an enable and a HALF value and outputs the square wave. Its divider and output clear when enable is low.
- The ms tick counter and the FSM stay in beep_player.

Test Plan:
- Setup: CLK_FREQ_HZ=100_000, so one ms tick = 100 cycles.
- Win melody: st edge with win=1.
  - beep half-periods, in cycles: 95 for C5, 75 for E5, 63 for G5, 47 for C6.
  - Each note lasts 15000 cycles, each gap 2000 cycles with beep=0.
  - over pulses once, 68000+2 cycles after acceptance; busy falls the cycle after.
- Fail melody: st edge with win=0.
  - beep half-periods 127, 151, 190 cycles, each note 30000 cycles.
  - over pulses at 96000+2 cycles.
  - Toggling win during playback changes nothing.
- Retrigger ignore: a second st edge 5000 cycles into the win melody causes no restart; over still comes at 68002. st held high afterwards produces no new melody.
- Abort: stop=1 at cycle 20000 of the win melody → next cycle beep=0, busy=0, and no over pulse ever arrives. stop=1 together with an st edge in IDLE → nothing starts.
- Reset: rst asserted asynchronously mid-note (between clock edges) → beep, busy and over are 0 before the next clk edge. After release, a fresh st edge plays the full melody from the first note.
